dfm_gate_counter: RTL and testbench
===================================

Name: dfm_gate_counter

Overview:
- Downstream stage of the SPI command decoder.
- Consumes its start pulse, gate-time byte and 3-bit readout byte address.
- Counts rising edges of two asynchronous external signals (A, B) over a programmable gate window.
- Holds the results in double-buffered registers and returns one selected result byte per address for SPI readout.

Parameters:
- GATE_UNIT, 100000, clk_i cycles per gate-time unit (1 ms at 100 MHz); minimum value 2.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-high reset
- gate_st_i  input  1  one-cycle measurement start pulse
- gate_time_i  input  8  gate length code; sampled with gate_st_i
- sig_a_i  input  1  external signal A, asynchronous to clk_i
- sig_b_i  input  1  external signal B, asynchronous to clk_i
- reg_rd_addr_i  input  3  result byte address
- reg_rd_data_o  output  8  selected result byte
- busy_o  output  1  measurement in progress
- done_o  output  1  valid results from a completed measurement

Behaviour:
- Reset (asynchronous, rst_i high) clears the following to 0: state, all counters, latched gate time, result registers, synchronizers, reg_rd_data_o, busy_o, done_o. State becomes IDLE.
- Reset mid-measurement aborts the measurement; previous results are lost.
- Input synchronization and edge detection:
  - sig_a_i and sig_b_i each pass through 2 synchronizer flops plus 1 history flop.
  - Edge pulse = sync & ~hist.
  - A rising input edge produces an edge pulse 3 cycles later.
  - An input pulse must be held ≥2 clk_i cycles to be counted.
- States:
  - IDLE -> GATE: on gate_st_i.
  - GATE -> LATCH: after the final gate cycle.
  - LATCH -> DONE: unconditional, 1 cycle.
  - DONE -> GATE: on gate_st_i.
  - gate_st_i is ignored in GATE and LATCH.
- Start (gate_st_i=1 in IDLE or DONE):
  - Latch gate_time_i.
  - Clear the unit counter, unit index, cnt_a and cnt_b.
  - Enter GATE on the next edge.
- Gate length is exactly (gate_time+1)*GATE_UNIT cycles in GATE.
  - gate_time=0 gives 1 unit; 255 gives 256 units.
  - The unit counter runs 0..GATE_UNIT-1 and wraps; the unit index increments on each wrap.
  - Final gate cycle: unit index == latched gate_time and unit counter == GATE_UNIT-1.
- Counting:
  - cnt_a and cnt_b are 32-bit and increment on each edge pulse seen while in GATE, including the final gate cycle.
  - Counters saturate at 32'hFFFF_FFFF with no wrap.
- LATCH (1 cycle): copy cnt_a to res_a and cnt_b to res_b.
- Double buffering: res_a and res_b change only in LATCH. Readout during GATE returns the previous results.
- busy_o: 1 in GATE and LATCH, otherwise 0. It rises on the cycle after gate_st_i.
- done_o: 1 in DONE only. It rises on the cycle after LATCH and clears on the cycle after a new start.
- Readout byte map (big-endian, address 0 first):
  - addr 0..3 = res_a[31:24], res_a[23:16], res_a[15:8], res_a[7:0]
  - addr 4..7 = res_b[31:24], res_b[23:16], res_b[15:8], res_b[7:0]
- reg_rd_data_o is registered: 1-cycle latency from reg_rd_addr_i in every state. It updates every cycle.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately; after release, busy_o=0, done_o=0, reg_rd_data_o=00 for every address.
- Basic measurement (GATE_UNIT=10, sig_a period 5 clk, sig_b period 10 clk, both running before start), gate_time=4:
  - busy_o high exactly 51 cycles (50 GATE + 1 LATCH);
  - done_o rises the following cycle;
  - res_a=10, res_b=5.
- Readback after the basic measurement: addr 0..7 in sequence -> bytes 00 00 00 0A 00 00 00 05, each one cycle after its address.
- Ignored start: gate_st_i with gate_time=200, issued 20 cycles into the gate_time=4 measurement -> gate still ends at 50 cycles and counts are unchanged from the basic case.
- Double buffer and minimum gate:
  - Start with gate_time=0 while holding results 10/5, sig_a period 2 clk.
  - During GATE, addr 3 reads 0A.
  - After 10 gate cycles, done_o rises again and addr 3 reads 05.
- Abort: assert rst_i during GATE -> state IDLE, busy_o=0, done_o=0, all addresses read 00; a new start then completes normally.

Source files
------------

// File: rtl/dfm_gate_counter.sv
// Gate-window edge counter for two asynchronous inputs. Results are double-buffered
// and read back one byte per address for the SPI register interface.
module dfm_gate_counter #(
    parameter int unsigned GATE_UNIT = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       gate_st_i,
    input  logic [7:0] gate_time_i,
    input  logic       sig_a_i,
    input  logic       sig_b_i,
    input  logic [2:0] reg_rd_addr_i,
    output logic [7:0] reg_rd_data_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned UnitW = $clog2(GATE_UNIT);
    localparam logic [UnitW-1:0] UnitLast = UnitW'(GATE_UNIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGate,
        StLatch,
        StDone
    } state_e;

    state_e           state_q;
    logic [UnitW-1:0] unit_cnt_q;
    logic [7:0]       unit_idx_q;
    logic [7:0]       gate_time_q;
    logic [31:0]      cnt_a_q;
    logic [31:0]      cnt_b_q;
    logic [31:0]      res_a_q;
    logic [31:0]      res_b_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       rd_data_q;

    logic [1:0]       a_sync_q;
    logic [1:0]       b_sync_q;
    logic             a_hist_q;
    logic             b_hist_q;
    logic             a_edge;
    logic             b_edge;
    logic             gate_last;
    logic [7:0]       rd_byte;

    // Two-flop synchronizer plus one history flop per input; rising edges become
    // single-cycle pulses three cycles after the input transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            a_hist_q <= 1'b0;
            b_hist_q <= 1'b0;
        end else begin
            a_sync_q <= {a_sync_q[0], sig_a_i};
            b_sync_q <= {b_sync_q[0], sig_b_i};
            a_hist_q <= a_sync_q[1];
            b_hist_q <= b_sync_q[1];
        end
    end

    assign a_edge    = a_sync_q[1] & ~a_hist_q;
    assign b_edge    = b_sync_q[1] & ~b_hist_q;
    assign gate_last = (unit_idx_q == gate_time_q) && (unit_cnt_q == UnitLast);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            unit_cnt_q  <= '0;
            unit_idx_q  <= '0;
            gate_time_q <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (gate_st_i) begin
                        gate_time_q <= gate_time_i;
                        unit_cnt_q  <= '0;
                        unit_idx_q  <= '0;
                        cnt_a_q     <= '0;
                        cnt_b_q     <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= StGate;
                    end
                end
                StGate: begin
                    cnt_a_q <= sat_inc(cnt_a_q, a_edge);
                    cnt_b_q <= sat_inc(cnt_b_q, b_edge);
                    if (unit_cnt_q == UnitLast) begin
                        unit_cnt_q <= '0;
                        unit_idx_q <= unit_idx_q + 8'd1;
                    end else begin
                        unit_cnt_q <= unit_cnt_q + UnitW'(1);
                    end
                    if (gate_last) begin
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    // Only place the readout buffers change.
                    res_a_q <= cnt_a_q;
                    res_b_q <= cnt_b_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        unique case (reg_rd_addr_i)
            3'd0: rd_byte = res_a_q[31:24];
            3'd1: rd_byte = res_a_q[23:16];
            3'd2: rd_byte = res_a_q[15:8];
            3'd3: rd_byte = res_a_q[7:0];
            3'd4: rd_byte = res_b_q[31:24];
            3'd5: rd_byte = res_b_q[23:16];
            3'd6: rd_byte = res_b_q[15:8];
            3'd7: rd_byte = res_b_q[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_byte;
        end
    end

    assign reg_rd_data_o = rd_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_dfm_gate_counter.sv
// Randomised and directed bench for dfm_gate_counter against a countdown-based model.
module tb_dfm_gate_counter;

    localparam int unsigned GU = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gate_st = 1'b0;
    logic [7:0] gate_time = 8'd0;
    logic       sig_a = 1'b0;
    logic       sig_b = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dfm_gate_counter #(.GATE_UNIT(GU)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .gate_st_i     (gate_st),
        .gate_time_i   (gate_time),
        .sig_a_i       (sig_a),
        .sig_b_i       (sig_b),
        .reg_rd_addr_i (rd_addr),
        .reg_rd_data_o (rd_data),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [2:0] a, input logic [31:0] ra,
                                           input logic [31:0] rb);
        logic [31:0] w;
        w = a[2] ? rb : ra;
        return 8'(w >> (8 * (3 - int'(a[1:0]))));
    endfunction

    // Input signal generator: periodic square waves or random levels.
    int per_a = 5;
    int per_b = 10;
    bit rand_sig = 1'b0;
    int ph = 0;
    initial forever begin
        @(negedge clk);
        ph++;
        if (rand_sig) begin
            sig_a = 1'($urandom);
            sig_b = 1'($urandom);
        end else begin
            sig_a = (ph % per_a) < (per_a / 2);
            sig_b = (ph % per_b) < (per_b / 2);
        end
    end

    // Model: a gate is a countdown of (gate_time+1)*GU counting cycles followed by
    // one latch cycle; an input edge counts when its level seen two samples back
    // is high and three samples back is low.
    bit [2:0]    pa, pb;
    bit          ea, eb;
    bit          m_busy, m_done;
    int          m_left;
    logic [31:0] m_ca, m_cb, m_ra, m_rb;
    logic [7:0]  m_rd;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            pa = '0; pb = '0;
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_ca = '0; m_cb = '0; m_ra = '0; m_rb = '0; m_rd = '0;
        end else begin
            ea = pa[1] & ~pa[2];
            eb = pb[1] & ~pb[2];
            m_rd = rd_byte(rd_addr, m_ra, m_rb);
            if (m_busy) begin
                if (m_left > 0) begin
                    if (ea && m_ca != 32'hFFFF_FFFF) m_ca = m_ca + 1;
                    if (eb && m_cb != 32'hFFFF_FFFF) m_cb = m_cb + 1;
                    m_left = m_left - 1;
                end else begin
                    m_ra = m_ca; m_rb = m_cb;
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end else if (gate_st) begin
                m_left = (int'(gate_time) + 1) * int'(GU);
                m_ca = '0; m_cb = '0;
                m_busy = 1'b1; m_done = 1'b0;
            end
            pa = {pa[1:0], sig_a};
            pb = {pb[1:0], sig_b};
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("busy_o", 32'(busy), 32'(m_busy));
        check("done_o", 32'(done), 32'(m_done));
        check("reg_rd_data_o", 32'(rd_data), 32'(m_rd));
    end

    // Start a measurement; count busy cycles until busy drops, bounded.
    task automatic measure(input logic [7:0] gt, input int ign_at, output int nbusy,
                           output bit done_ok, output logic [7:0] mid);
        @(negedge clk);
        gate_st = 1'b1;
        gate_time = gt;
        nbusy = 0;
        done_ok = 1'b0;
        mid = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            gate_st = (i == ign_at);
            gate_time = (i == ign_at) ? 8'd200 : gt;
            if (i == 3) mid = rd_data;
            if (busy) begin
                nbusy++;
            end else begin
                done_ok = done;
                return;
            end
        end
    endtask

    task automatic readback(input string name, input logic [31:0] ra, input logic [31:0] rb);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            @(negedge clk);
            check($sformatf("%s addr%0d", name, a), 32'(rd_data), 32'(rd_byte(3'(a), ra, rb)));
        end
    endtask

    int nb;
    bit dk;
    logic [7:0] mid;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        readback("reset", 32'd0, 32'd0);

        // Basic: period 5 / period 10, gate_time 4 -> 50 gate cycles.
        measure(8'd4, -1, nb, dk, mid);
        check("basic busy cycles", 32'(nb), 32'd51);
        check("basic done follows", 32'(dk), 32'd1);
        readback("basic", 32'd10, 32'd5);

        // Start request mid-gate must be ignored.
        measure(8'd4, 20, nb, dk, mid);
        check("ignored busy cycles", 32'(nb), 32'd51);
        check("ignored done follows", 32'(dk), 32'd1);
        readback("ignored", 32'd10, 32'd5);

        // Minimum gate while old results must stay visible.
        per_a = 2;
        repeat (6) @(negedge clk);
        rd_addr = 3'd3;
        measure(8'd0, -1, nb, dk, mid);
        check("dbuf read during gate", 32'(mid), 32'h0A);
        check("min busy cycles", 32'(nb), 32'd11);
        check("min done follows", 32'(dk), 32'd1);
        readback("min", 32'd5, 32'd1);

        // Abort with an asynchronous reset mid-cycle during GATE.
        per_a = 5;
        @(negedge clk);
        gate_st = 1'b1;
        gate_time = 8'd4;
        @(negedge clk);
        gate_st = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        readback("abort", 32'd0, 32'd0);
        measure(8'd1, -1, nb, dk, mid);
        check("post-abort busy cycles", 32'(nb), 32'd21);
        check("post-abort done", 32'(dk), 32'd1);
        readback("post-abort", 32'd4, 32'd2);

        // Longest gate: 256 units.
        measure(8'd255, -1, nb, dk, mid);
        check("max busy cycles", 32'(nb), 32'd2561);
        readback("max", 32'd512, 32'd256);

        // Random inputs, addresses, starts and occasional resets.
        rand_sig = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < int'($urandom_range(5, 60)); c++) begin
                @(negedge clk);
                rd_addr = 3'($urandom);
                gate_st = ($urandom_range(0, 15) == 0);
                gate_time = 8'($urandom_range(0, 3));
                if ($urandom_range(0, 199) == 0) begin
                    #($urandom_range(1, 4)) rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
        end
        @(negedge clk);
        gate_st = 1'b0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
